wb_commit_multi: RTL and testbench
==================================

Name: wb_commit_multi

Overview:
Multi-lane writeback/commit stage for the LoongArch pipeline, parametrised in issue width.
- Holds its own stage register for one MEM→WB instruction group (lane 0 = oldest).
- Selects the first excepting or refetching lane, commits the older lanes and kills the younger ones.
- Emits a single flush/exception/refetch request to CSR and fetch, and holds a post-flush bubble FSM.
- Keeps a retired-instruction counter.

Parameters:
LANES, 2, instructions per group
DATA_W, 32, register data width
REG_AW, 5, register address width
EXC_W, 20, per-lane exception vector width
CNT_W, 64, retire counter width
FLUSH_HOLD, 1, cycles allowin is held low after a flush (0 allowed)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
mw_valid_i  in  1  group valid from MEM
mw_lane_valid_i  in  LANES  per-lane valid
mw_pc_i  in  LANES*32  lane PCs
mw_we_i  in  LANES  regfile write request
mw_waddr_i  in  LANES*REG_AW  write address
mw_wdata_i  in  LANES*DATA_W  write data
mw_excep_i  in  LANES*EXC_W  exception vector (bit0 INT, bit16 ERTN)
mw_refetch_i  in  LANES  refetch request (TLB/CSR-write instruction)
wb_allowin_o  out  1  stage can accept a group
rfb_allowin_i  in  1  downstream accepts
wb_to_rfb_valid_o  out  1  group leaving the stage
regs_we_o  out  LANES  committed write enables
regs_waddr_o  out  LANES*REG_AW  write addresses
regs_wdata_o  out  LANES*DATA_W  write data
flush_o  out  1  pipeline flush pulse
flush_pc_o  out  32  refetch target (0 for exception/ertn)
excep_en_o  out  1  exception taken
ertn_en_o  out  1  ertn taken
refetch_en_o  out  1  refetch flush taken
excep_type_o  out  EXC_W  vector of the selected lane
excep_pc_o  out  32  PC of the selected lane
retire_cnt_o  out  CNT_W  retired-instruction count

Behaviour:
- Reset:
  - wb_valid=0, FSM=RUN, retire_cnt=0.
  - All outputs 0, except wb_allowin_o=1.
- Stage register:
  - When wb_allowin_o=1, the group is latched and wb_valid<=mw_valid_i.
  - When wb_allowin_o=0, the group is held.
- Handshake:
  - ready_go=1.
  - wb_allowin_o = (FSM==RUN) & (!wb_valid | rfb_allowin_i).
  - wb_to_rfb_valid_o = wb_valid.
  - fire = wb_valid & rfb_allowin_i.
- Lane selection:
  - A lane is "special" when lane_valid & (|excep | refetch).
  - k = the lowest-index special lane.
  - Lanes <k commit.
  - Lane k commits only if refetch=1 and excep==0.
  - Lanes >k are killed.
  - With no special lane, every valid lane commits.
- Classification of lane k:
  - ertn_en when excep has only bit16 set.
  - excep_en when excep has any other bit set (INT included).
  - refetch_en when excep==0 & refetch=1.
  - These three are mutually exclusive.
- Flush outputs:
  - All flush outputs are combinational and qualified by fire. They are 0 unless fire=1.
  - flush_o = fire & (excep_en|ertn_en|refetch_en).
  - flush_pc_o = pc[k]+4 for refetch, else 0.
  - excep_pc_o = pc[k]; excep_type_o = excep[k].
- Regfile writes:
  - regs_we_o[i] = fire & commit[i] & we[i] & (waddr[i]!=0).
  - Same-address conflict between committing lanes: the younger lane wins and the older lane's we is masked.
  - Data and address pass through unmodified.
- FSM:
  - RUN→HOLD on flush_o when FLUSH_HOLD>0. A down-counter is loaded with FLUSH_HOLD-1.
  - HOLD→RUN when the counter reaches 0.
  - In HOLD: allowin=0 and wb_valid=0.
  - On a flush edge, wb_valid<=0 regardless of mw_valid_i, because upstream is being flushed.
- Counter:
  - On fire, retire_cnt += popcount(commit & lane_valid). Excepting and ertn lanes are not counted.
  - Wraps modulo 2^CNT_W.
- rfb_allowin_i=0: no writes, no flush, no count; the group is held unchanged.
- Asynchronous reset mid-HOLD or mid-stall: immediately returns to reset values.

Decomposition:
- Shared package wb_pkg holds:
  - exception bit positions (INT=0, ERTN=16);
  - the FSM state enum (RUN, HOLD);
  - width constants.
- Sub-module wb_lane_arbiter: combinational. Takes lane_valid/excep/refetch and returns k, the commit mask, and the class flags.

Test Plan:
1. LANES=2, both lanes valid, we=1, waddr 3/4, no exceptions, fire → regs_we_o=2'b11 in the same cycle, retire_cnt 0→2, flush_o=0.
2. Lane1 excep bit11 (INE), pc=0x1C000008; lane0 normal → regs_we_o=2'b01, excep_en_o=1, excep_pc_o=0x1C000008, flush_o high 1 cycle, wb_allowin_o low 1 cycle after, retire_cnt +1.
3. Lane0 refetch=1, pc=0x1C000010 → lane0 commits, lane1 killed, refetch_en_o=1, flush_pc_o=0x1C000014, retire_cnt +1.
4. Both lanes write r5 → regs_we_o=2'b10; both write r0 → regs_we_o=2'b00, retire_cnt +2.
5. Valid group with rfb_allowin_i=0 for 3 cycles, then 1 → no writes or count while stalled; a single commit on the release cycle.
6. CNT_W=4, cnt=15, commit 2 → cnt=1; assert rst_n=0 during HOLD → all outputs 0, wb_allowin_o=1 on release.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the multi-lane writeback/commit stage:
// exception bit positions, the post-flush FSM states and common widths.
package wb_pkg;

  localparam int EXC_INT_BIT  = 0;
  localparam int EXC_ERTN_BIT = 16;
  localparam int PC_W         = 32;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_commit_multi_if.sv
// MEM->WB group, regfile write port, flush request and retire count bundle.
// Handshake: a group moves MEM->WB when mw_valid_i & wb_allowin_o, and leaves WB when wb_to_rfb_valid_o & rfb_allowin_i.
interface wb_commit_multi_if #(
  parameter int LANES  = 2,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int EXC_W  = 20,
  parameter int CNT_W  = 64
);
  logic                    mw_valid_i;
  logic [LANES-1:0]        mw_lane_valid_i;
  logic [LANES*32-1:0]     mw_pc_i;
  logic [LANES-1:0]        mw_we_i;
  logic [LANES*REG_AW-1:0] mw_waddr_i;
  logic [LANES*DATA_W-1:0] mw_wdata_i;
  logic [LANES*EXC_W-1:0]  mw_excep_i;
  logic [LANES-1:0]        mw_refetch_i;
  logic                    wb_allowin_o;
  logic                    rfb_allowin_i;
  logic                    wb_to_rfb_valid_o;
  logic [LANES-1:0]        regs_we_o;
  logic [LANES*REG_AW-1:0] regs_waddr_o;
  logic [LANES*DATA_W-1:0] regs_wdata_o;
  logic                    flush_o;
  logic [31:0]             flush_pc_o;
  logic                    excep_en_o;
  logic                    ertn_en_o;
  logic                    refetch_en_o;
  logic [EXC_W-1:0]        excep_type_o;
  logic [31:0]             excep_pc_o;
  logic [CNT_W-1:0]        retire_cnt_o;

  modport master (
    output mw_valid_i, mw_lane_valid_i, mw_pc_i, mw_we_i, mw_waddr_i, mw_wdata_i,
           mw_excep_i, mw_refetch_i, rfb_allowin_i,
    input  wb_allowin_o, wb_to_rfb_valid_o, regs_we_o, regs_waddr_o, regs_wdata_o,
           flush_o, flush_pc_o, excep_en_o, ertn_en_o, refetch_en_o, excep_type_o,
           excep_pc_o, retire_cnt_o
  );

  modport slave (
    input  mw_valid_i, mw_lane_valid_i, mw_pc_i, mw_we_i, mw_waddr_i, mw_wdata_i,
           mw_excep_i, mw_refetch_i, rfb_allowin_i,
    output wb_allowin_o, wb_to_rfb_valid_o, regs_we_o, regs_waddr_o, regs_wdata_o,
           flush_o, flush_pc_o, excep_en_o, ertn_en_o, refetch_en_o, excep_type_o,
           excep_pc_o, retire_cnt_o
  );
endinterface

// File: rtl/wb_lane_arbiter.sv
// Finds the oldest excepting/refetching lane, builds the commit mask and
// classifies that lane as exception, ertn or refetch.
module wb_lane_arbiter
  import wb_pkg::*;
#(
  parameter int LANES = 2,
  parameter int EXC_W = 20,
  parameter int KW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic [LANES-1:0]       i_lane_valid,
  input  logic [LANES*EXC_W-1:0] i_excep,
  input  logic [LANES-1:0]       i_refetch,
  output logic [KW-1:0]          o_k,
  output logic                   o_found,
  output logic [LANES-1:0]       o_commit,
  output logic                   o_excep_en,
  output logic                   o_ertn_en,
  output logic                   o_refetch_en
);

  localparam logic [EXC_W-1:0] ERTN_ONLY = EXC_W'(1) << EXC_ERTN_BIT;

  logic             w_found;
  logic [KW-1:0]    w_k;
  logic [EXC_W-1:0] w_ex_i;
  logic [EXC_W-1:0] w_ex_k;
  logic             w_rf_k;

  always_comb begin
    w_found  = 1'b0;
    w_k      = '0;
    w_ex_i   = '0;
    w_ex_k   = '0;
    w_rf_k   = 1'b0;
    o_commit = '0;
    for (int i = 0; i < LANES; i++) begin
      w_ex_i = i_excep[i*EXC_W +: EXC_W];
      // Once the special lane is found every younger lane stays killed.
      if (!w_found) begin
        if (i_lane_valid[i] && ((|w_ex_i) || i_refetch[i])) begin
          w_found     = 1'b1;
          w_k         = KW'(i);
          w_ex_k      = w_ex_i;
          w_rf_k      = i_refetch[i];
          o_commit[i] = (w_ex_i == '0) & i_refetch[i];
        end else begin
          o_commit[i] = i_lane_valid[i];
        end
      end
    end
  end

  assign o_found      = w_found;
  assign o_k          = w_k;
  assign o_ertn_en    = w_found & (w_ex_k == ERTN_ONLY);
  assign o_excep_en   = w_found & (|w_ex_k) & (w_ex_k != ERTN_ONLY);
  assign o_refetch_en = w_found & (w_ex_k == '0) & w_rf_k;

endmodule

// File: rtl/wb_commit_multi.sv
// Multi-lane writeback/commit stage: stage register, commit/kill selection,
// flush request generation, post-flush bubble FSM and retire counter.
module wb_commit_multi
  import wb_pkg::*;
#(
  parameter int LANES      = 2,
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int EXC_W      = 20,
  parameter int CNT_W      = 64,
  parameter int FLUSH_HOLD = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  wb_commit_multi_if.slave   bus,
  output wb_state_e          o_dbg_state
);

  localparam int KW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int HW = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = (FLUSH_HOLD > 0) ? HW'(FLUSH_HOLD - 1) : '0;

  logic                    r_valid;
  logic [LANES-1:0]        r_lane_valid;
  logic [LANES*32-1:0]     r_pc;
  logic [LANES-1:0]        r_we;
  logic [LANES*REG_AW-1:0] r_waddr;
  logic [LANES*DATA_W-1:0] r_wdata;
  logic [LANES*EXC_W-1:0]  r_excep;
  logic [LANES-1:0]        r_refetch;
  logic [CNT_W-1:0]        r_retire_cnt;
  wb_state_e               r_state;
  wb_state_e               w_state_nxt;
  logic [HW-1:0]           r_hold_cnt;
  logic [HW-1:0]           w_hold_cnt_nxt;

  logic                    w_allowin;
  logic                    w_fire;
  logic                    w_flush;
  logic [KW-1:0]           w_k;
  logic                    w_found;
  logic [LANES-1:0]        w_commit;
  logic                    w_excep_en;
  logic                    w_ertn_en;
  logic                    w_refetch_en;
  logic [31:0]             w_sel_pc;
  logic [EXC_W-1:0]        w_sel_exc;
  logic [LANES-1:0]        w_cwe;
  logic [LANES-1:0]        w_regs_we;
  logic [CNT_W-1:0]        w_retire_inc;

  assign w_allowin = (r_state == ST_RUN) & (~r_valid | bus.rfb_allowin_i);
  assign w_fire    = r_valid & bus.rfb_allowin_i;
  assign w_flush   = w_fire & (w_excep_en | w_ertn_en | w_refetch_en);

  wb_lane_arbiter #(.LANES(LANES), .EXC_W(EXC_W), .KW(KW)) u_arb (
    .i_lane_valid (r_lane_valid),
    .i_excep      (r_excep),
    .i_refetch    (r_refetch),
    .o_k          (w_k),
    .o_found      (w_found),
    .o_commit     (w_commit),
    .o_excep_en   (w_excep_en),
    .o_ertn_en    (w_ertn_en),
    .o_refetch_en (w_refetch_en)
  );

  always_comb begin
    w_sel_pc     = '0;
    w_sel_exc    = '0;
    w_retire_inc = '0;
    for (int i = 0; i < LANES; i++) begin
      if (KW'(i) == w_k) begin
        w_sel_pc  = r_pc[i*32 +: 32];
        w_sel_exc = r_excep[i*EXC_W +: EXC_W];
      end
      w_retire_inc = w_retire_inc + CNT_W'(w_commit[i]);
    end
  end

  // A younger committing lane writing the same register hides the older write.
  always_comb begin
    w_cwe     = '0;
    w_regs_we = '0;
    for (int i = 0; i < LANES; i++) begin
      w_cwe[i] = w_commit[i] & r_we[i] & (r_waddr[i*REG_AW +: REG_AW] != '0);
    end
    for (int i = 0; i < LANES; i++) begin
      w_regs_we[i] = w_fire & w_cwe[i];
      for (int j = i + 1; j < LANES; j++) begin
        if (w_cwe[j] && (r_waddr[j*REG_AW +: REG_AW] == r_waddr[i*REG_AW +: REG_AW])) begin
          w_regs_we[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_hold_cnt_nxt = r_hold_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_flush && (FLUSH_HOLD > 0)) begin
          w_state_nxt    = ST_HOLD;
          w_hold_cnt_nxt = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (r_hold_cnt == '0) w_state_nxt = ST_RUN;
        else                  w_hold_cnt_nxt = r_hold_cnt - 1'b1;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end

  // Upstream is being flushed on a flush edge, so whatever it offers is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_lane_valid <= '0;
      r_pc         <= '0;
      r_we         <= '0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_excep      <= '0;
      r_refetch    <= '0;
    end else if (w_flush || (r_state == ST_HOLD)) begin
      r_valid <= 1'b0;
    end else if (w_allowin) begin
      r_valid      <= bus.mw_valid_i;
      r_lane_valid <= bus.mw_lane_valid_i;
      r_pc         <= bus.mw_pc_i;
      r_we         <= bus.mw_we_i;
      r_waddr      <= bus.mw_waddr_i;
      r_wdata      <= bus.mw_wdata_i;
      r_excep      <= bus.mw_excep_i;
      r_refetch    <= bus.mw_refetch_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_retire_cnt <= '0;
    else if (w_fire) r_retire_cnt <= r_retire_cnt + w_retire_inc;
  end

  assign bus.wb_allowin_o      = w_allowin;
  assign bus.wb_to_rfb_valid_o = r_valid;
  assign bus.regs_we_o         = w_regs_we;
  assign bus.regs_waddr_o      = r_waddr;
  assign bus.regs_wdata_o      = r_wdata;
  assign bus.flush_o           = w_flush;
  assign bus.flush_pc_o        = (w_fire & w_refetch_en) ? (w_sel_pc + 32'd4) : 32'd0;
  assign bus.excep_en_o        = w_fire & w_excep_en;
  assign bus.ertn_en_o         = w_fire & w_ertn_en;
  assign bus.refetch_en_o      = w_fire & w_refetch_en;
  assign bus.excep_type_o      = (w_fire & w_found) ? w_sel_exc : '0;
  assign bus.excep_pc_o        = (w_fire & w_found) ? w_sel_pc : 32'd0;
  assign bus.retire_cnt_o      = r_retire_cnt;
  assign o_dbg_state           = r_state;

endmodule

// File: tb/tb_wb_commit_multi.sv
// Bench for wb_commit_multi: table of commit groups checked through an expected
// queue, plus hand sequences for stall, counter wrap and reset during the flush bubble.
module tb_wb_commit_multi;
  import wb_pkg::*;

  localparam int LANES = 2, DATA_W = 32, REG_AW = 5, EXC_W = 20, CNT_W = 4;
  localparam int EW = 2 + 3 + 32 + 32 + 20 + 10 + 64;

  typedef struct {
    logic [1:0]  lv;
    logic [31:0] pc0;
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [19:0] ex0, ex1;
    logic [1:0]  rf;
    logic [1:0]  e_we;
    logic [2:0]  e_cls;   // {excep_en, ertn_en, refetch_en}
    logic [31:0] e_fpc, e_epc;
    logic [19:0] e_etype;
    int          e_ret;
  } vec_t;

  logic clk, rst_n;
  wb_state_e dbg_state;
  int n_checks, n_errors;
  logic [CNT_W-1:0] model_cnt;
  logic [EW-1:0] exp_q[$];
  vec_t vecs[12];

  wb_commit_multi_if #(.LANES(LANES), .DATA_W(DATA_W), .REG_AW(REG_AW),
                       .EXC_W(EXC_W), .CNT_W(CNT_W)) bus ();

  wb_commit_multi #(.LANES(LANES), .DATA_W(DATA_W), .REG_AW(REG_AW), .EXC_W(EXC_W),
                    .CNT_W(CNT_W), .FLUSH_HOLD(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  function automatic vec_t mk(logic [1:0] lv, logic [31:0] pc0, logic [1:0] we,
                              logic [4:0] wa0, logic [4:0] wa1, logic [19:0] ex0,
                              logic [19:0] ex1, logic [1:0] rf, logic [1:0] e_we,
                              logic [2:0] e_cls, logic [31:0] e_fpc, logic [31:0] e_epc,
                              logic [19:0] e_etype, int e_ret);
    vec_t v;
    v.lv = lv; v.pc0 = pc0; v.we = we; v.wa0 = wa0; v.wa1 = wa1;
    v.ex0 = ex0; v.ex1 = ex1; v.rf = rf; v.e_we = e_we; v.e_cls = e_cls;
    v.e_fpc = e_fpc; v.e_epc = e_epc; v.e_etype = e_etype; v.e_ret = e_ret;
    return v;
  endfunction

  // driver
  task automatic drive_group(input vec_t v, input logic [31:0] d0, input logic [31:0] d1);
    bus.mw_valid_i      = 1'b1;
    bus.mw_lane_valid_i = v.lv;
    bus.mw_pc_i         = {v.pc0 + 32'd4, v.pc0};
    bus.mw_we_i         = v.we;
    bus.mw_waddr_i      = {v.wa1, v.wa0};
    bus.mw_wdata_i      = {d1, d0};
    bus.mw_excep_i      = {v.ex1, v.ex0};
    bus.mw_refetch_i    = v.rf;
  endtask

  task automatic scramble_mw(input logic valid);
    bus.mw_valid_i      = valid;
    bus.mw_lane_valid_i = 2'($urandom_range(0, 3));
    bus.mw_pc_i         = {$urandom, $urandom};
    bus.mw_we_i         = 2'($urandom_range(0, 3));
    bus.mw_waddr_i      = 10'($urandom);
    bus.mw_wdata_i      = {$urandom, $urandom};
    bus.mw_excep_i      = {20'd0, 20'($urandom_range(1, 255))};
    bus.mw_refetch_i    = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_allowin(input string name);
    int n;
    n = 0;
    while (!bus.wb_allowin_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) timeout({name, " allowin"});
  endtask

  // scoreboard compare of one leaving group against the queue head
  task automatic compare_out(input string name, input logic check_special);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      timeout({name, " empty queue"});
      return;
    end
    e = exp_q.pop_front();
    check({name, " rfb_valid"}, 64'(bus.wb_to_rfb_valid_o), 64'd1);
    check({name, " regs_we"}, 64'(bus.regs_we_o), 64'(e[EW-1 -: 2]));
    check({name, " class"}, 64'({bus.excep_en_o, bus.ertn_en_o, bus.refetch_en_o}),
          64'(e[EW-3 -: 3]));
    check({name, " flush"}, 64'(bus.flush_o), 64'(|e[EW-3 -: 3]));
    check({name, " flush_pc"}, 64'(bus.flush_pc_o), 64'(e[EW-6 -: 32]));
    if (check_special) begin
      check({name, " excep_pc"}, 64'(bus.excep_pc_o), 64'(e[EW-38 -: 32]));
      check({name, " excep_type"}, 64'(bus.excep_type_o), 64'(e[EW-70 -: 20]));
    end
    check({name, " waddr"}, 64'(bus.regs_waddr_o), 64'(e[73:64]));
    check({name, " wdata"}, bus.regs_wdata_o, e[63:0]);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    logic [31:0] d0, d1;
    int n;
    wait_allowin(name);
    d0 = $urandom;
    d1 = $urandom;
    bus.rfb_allowin_i = 1'b1;
    drive_group(v, d0, d1);
    exp_q.push_back({v.e_we, v.e_cls, v.e_fpc, v.e_epc, v.e_etype, v.wa1, v.wa0, d1, d0});
    @(posedge clk); #1;
    scramble_mw(1'b0);
    n = 0;
    while (!bus.wb_to_rfb_valid_o && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 10) timeout({name, " rfb_valid"});
    @(negedge clk);
    compare_out(name, |v.e_cls);
    @(posedge clk); #1;
    model_cnt = model_cnt + CNT_W'(v.e_ret);
    check({name, " retire_cnt"}, 64'(bus.retire_cnt_o), 64'(model_cnt));
    if (|v.e_cls) begin
      check({name, " bubble allowin"}, 64'(bus.wb_allowin_o), 64'd0);
      check({name, " bubble state"}, 64'(dbg_state), 64'(ST_HOLD));
      check({name, " flush pulse"}, 64'(bus.flush_o), 64'd0);
    end else begin
      check({name, " allowin"}, 64'(bus.wb_allowin_o), 64'd1);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, " allowin"}, 64'(bus.wb_allowin_o), 64'd1);
    check({name, " rfb_valid"}, 64'(bus.wb_to_rfb_valid_o), 64'd0);
    check({name, " regs_we"}, 64'(bus.regs_we_o), 64'd0);
    check({name, " flush"}, 64'({bus.flush_o, bus.excep_en_o, bus.ertn_en_o, bus.refetch_en_o}), 64'd0);
    check({name, " flush_pc"}, 64'(bus.flush_pc_o), 64'd0);
    check({name, " excep_pc"}, 64'(bus.excep_pc_o), 64'd0);
    check({name, " excep_type"}, 64'(bus.excep_type_o), 64'd0);
    check({name, " waddr"}, 64'(bus.regs_waddr_o), 64'd0);
    check({name, " retire_cnt"}, 64'(bus.retire_cnt_o), 64'd0);
    check({name, " state"}, 64'(dbg_state), 64'(ST_RUN));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_cnt = '0;
    rst_n = 1'b0;
    bus.rfb_allowin_i = 1'b1;
    scramble_mw(1'b0);

    //          lv     pc0           we     wa0 wa1 ex0       ex1       rf     e_we   cls     fpc           epc           etype     ret
    vecs[0]  = mk(2'b11, 32'h1C000000, 2'b11, 3,  4,  20'h0,     20'h0,    2'b00, 2'b11, 3'b000, 32'h0,        32'h0,        20'h0,     2);
    vecs[1]  = mk(2'b11, 32'h1C000004, 2'b11, 6,  7,  20'h0,     20'h00800,2'b00, 2'b01, 3'b100, 32'h0,        32'h1C000008, 20'h00800, 1);
    vecs[2]  = mk(2'b11, 32'h1C000010, 2'b11, 7,  8,  20'h0,     20'h0,    2'b01, 2'b01, 3'b001, 32'h1C000014, 32'h1C000010, 20'h0,     1);
    vecs[3]  = mk(2'b11, 32'h1C000020, 2'b11, 5,  5,  20'h0,     20'h0,    2'b00, 2'b10, 3'b000, 32'h0,        32'h0,        20'h0,     2);
    vecs[4]  = mk(2'b11, 32'h1C000030, 2'b11, 0,  0,  20'h0,     20'h0,    2'b00, 2'b00, 3'b000, 32'h0,        32'h0,        20'h0,     2);
    vecs[5]  = mk(2'b11, 32'h1C000040, 2'b11, 9,  10, 20'h10000, 20'h0,    2'b00, 2'b00, 3'b010, 32'h0,        32'h1C000040, 20'h10000, 0);
    vecs[6]  = mk(2'b11, 32'h1C000050, 2'b11, 11, 12, 20'h00001, 20'h0,    2'b01, 2'b00, 3'b100, 32'h0,        32'h1C000050, 20'h00001, 0);
    vecs[7]  = mk(2'b10, 32'h1C000060, 2'b11, 13, 14, 20'h00800, 20'h0,    2'b00, 2'b10, 3'b000, 32'h0,        32'h0,        20'h0,     1);
    vecs[8]  = mk(2'b11, 32'h1C000070, 2'b11, 15, 16, 20'h10008, 20'h0,    2'b00, 2'b00, 3'b100, 32'h0,        32'h1C000070, 20'h10008, 0);
    vecs[9]  = mk(2'b11, 32'h1C000080, 2'b11, 17, 18, 20'h0,     20'h0,    2'b10, 2'b11, 3'b001, 32'h1C000088, 32'h1C000084, 20'h0,     2);
    vecs[10] = mk(2'b11, 32'h1C000090, 2'b10, 19, 20, 20'h0,     20'h0,    2'b00, 2'b10, 3'b000, 32'h0,        32'h0,        20'h0,     2);
    vecs[11] = mk(2'b00, 32'h1C0000A0, 2'b11, 21, 22, 20'h00800, 20'h0,    2'b01, 2'b00, 3'b000, 32'h0,        32'h0,        20'h0,     0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Stall: group sits in WB for 3 cycles while upstream offers junk.
    begin
      vec_t v;
      logic [31:0] d0, d1;
      v = mk(2'b11, 32'h1C0000B0, 2'b11, 23, 24, 20'h0, 20'h0, 2'b00,
             2'b11, 3'b000, 32'h0, 32'h0, 20'h0, 2);
      wait_allowin("stall");
      d0 = $urandom;
      d1 = $urandom;
      bus.rfb_allowin_i = 1'b0;
      drive_group(v, d0, d1);
      exp_q.push_back({v.e_we, v.e_cls, v.e_fpc, v.e_epc, v.e_etype, v.wa1, v.wa0, d1, d0});
      @(posedge clk); #1;
      scramble_mw(1'b1);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        check($sformatf("stall%0d regs_we", c), 64'(bus.regs_we_o), 64'd0);
        check($sformatf("stall%0d flush", c), 64'(bus.flush_o), 64'd0);
        check($sformatf("stall%0d allowin", c), 64'(bus.wb_allowin_o), 64'd0);
        check($sformatf("stall%0d rfb_valid", c), 64'(bus.wb_to_rfb_valid_o), 64'd1);
        @(posedge clk); #1;
        check($sformatf("stall%0d retire_cnt", c), 64'(bus.retire_cnt_o), 64'(model_cnt));
      end
      bus.rfb_allowin_i = 1'b1;
      bus.mw_valid_i = 1'b0;
      @(negedge clk);
      compare_out("stall release", 1'b0);
      @(posedge clk); #1;
      model_cnt = model_cnt + CNT_W'(v.e_ret);
      check("stall release retire_cnt", 64'(bus.retire_cnt_o), 64'(model_cnt));
    end

    // Counter sits at 15 here; two more retirements wrap it to 1.
    check("pre-wrap retire_cnt", 64'(bus.retire_cnt_o), 64'd15);
    run_vec(mk(2'b11, 32'h1C0000C0, 2'b11, 25, 26, 20'h0, 20'h0, 2'b00,
               2'b11, 3'b000, 32'h0, 32'h0, 20'h0, 2), "wrap");
    check("cnt_wrap", 64'(bus.retire_cnt_o), 64'd1);

    // Flush, then reset asynchronously while the bubble is active.
    run_vec(mk(2'b11, 32'h1C0000D0, 2'b11, 27, 28, 20'h00800, 20'h0, 2'b00,
               2'b00, 3'b100, 32'h0, 32'h1C0000D0, 20'h00800, 0), "pre-reset flush");
    rst_n = 1'b0;
    #2;
    check_idle_outputs("hold reset");
    model_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-reset allowin", 64'(bus.wb_allowin_o), 64'd1);
    run_vec(vecs[0], "post-reset vec0");

    check("queue drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
